// File: rtl/irq_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer_ctrl
//  Purpose  : CSR-attached interrupt controller with a built-in interval
//             timer. Latches peripheral requests as pending (edge or level
//             semantics per source), masks them and presents a registered
//             32-bit interrupt vector to the CPU. The timer is internal
//             source index NSRC and always behaves as an edge source.
//  Ports    : sys_clk  - system clock
//             sys_rst  - asynchronous, active-high reset
//             csr_a    - CSR address; [13:10] bank, [3:0] register index
//             csr_we   - CSR write strobe (single cycle)
//             csr_di   - CSR write data
//             csr_do   - CSR read data, registered, 0 when bank not selected
//             irq_src  - peripheral requests (sys_clk domain)
//             irq_o    - interrupt vector to CPU; bits above NSRC read 0
//  Register map (index = csr_a[3:0]):
//             0 PENDING R/W1C   1 MASK RW   2 EDGE RW (bit NSRC reads 1)
//             3 CTRL {AUTO,EN}  4 RELOAD    5 COUNT   6..15 read 0
//  Revision : 1.0 - initial release
// ============================================================================
module irq_timer_ctrl #(
  parameter logic [3:0]  CSR_ADDR = 4'h4,
  parameter int unsigned NSRC     = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [13:0]     csr_a,
  input  logic            csr_we,
  input  logic [31:0]     csr_di,
  output logic [31:0]     csr_do,
  input  logic [NSRC-1:0] irq_src,
  output logic [31:0]     irq_o
);

  // Pending/mask vectors carry one extra bit for the timer source.
  localparam int unsigned NB = NSRC + 1;

  localparam logic [3:0] C_REG_PENDING = 4'd0;
  localparam logic [3:0] C_REG_MASK    = 4'd1;
  localparam logic [3:0] C_REG_EDGE    = 4'd2;
  localparam logic [3:0] C_REG_CTRL    = 4'd3;
  localparam logic [3:0] C_REG_RELOAD  = 4'd4;
  localparam logic [3:0] C_REG_COUNT   = 4'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NB-1:0]   pending_q, pending_d;
  logic [NB-1:0]   mask_q,    mask_d;
  logic [NSRC-1:0] edge_q,    edge_d;
  logic [NSRC-1:0] src_prev_q;
  logic            en_q,      en_d;
  logic            auto_q,    auto_d;
  logic [31:0]     reload_q,  reload_d;
  logic [31:0]     count_q,   count_d;
  logic [31:0]     csr_do_d;
  logic [31:0]     irq_d;

  // --------------------------------------------------------------------------
  // CSR decode
  // --------------------------------------------------------------------------
  logic       w_sel;
  logic [3:0] w_idx;
  logic       w_wr;
  logic       w_unused;

  assign w_sel = (csr_a[13:10] == CSR_ADDR);
  assign w_idx = csr_a[3:0];
  assign w_wr  = w_sel & csr_we;

  // Address bits between bank and register index are not decoded.
  assign w_unused = ^csr_a[9:4];

  // --------------------------------------------------------------------------
  // Timer and pending next-state
  // --------------------------------------------------------------------------
  logic          w_wr_count;
  logic          w_timer_evt;
  logic [NB-1:0] w_edge_full;
  logic [NB-1:0] w_src_full;
  logic [NB-1:0] w_prev_full;
  logic [NB-1:0] w_set;
  logic [NB-1:0] w_clr;

  assign w_wr_count = w_wr && (w_idx == C_REG_COUNT);

  // A COUNT write takes precedence, so it also swallows a terminal event.
  assign w_timer_evt = en_q && (count_q == 32'd0) && !w_wr_count;

  // The timer is appended as an edge source whose "previous" value is always
  // 0, so its set term reduces to the one-cycle event strobe itself.
  assign w_edge_full = {1'b1, edge_q};
  assign w_src_full  = {w_timer_evt, irq_src};
  assign w_prev_full = {1'b0, src_prev_q};

  assign w_set = (w_edge_full & w_src_full & ~w_prev_full) |
                 (~w_edge_full & w_src_full);
  assign w_clr = (w_wr && (w_idx == C_REG_PENDING)) ? csr_di[NB-1:0] : '0;

  always_comb begin
    // Set beats clear; a held level source therefore survives its own W1C.
    pending_d = w_set | (pending_q & ~w_clr);

    mask_d   = mask_q;
    edge_d   = edge_q;
    en_d     = en_q;
    auto_d   = auto_q;
    reload_d = reload_q;
    count_d  = count_q;

    if (w_wr) begin
      case (w_idx)
        C_REG_MASK:   mask_d   = csr_di[NB-1:0];
        C_REG_EDGE:   edge_d   = csr_di[NSRC-1:0];
        C_REG_CTRL: begin
          en_d   = csr_di[0];
          auto_d = csr_di[1];
        end
        C_REG_RELOAD: reload_d = csr_di;
        default:      ;
      endcase
    end

    if (w_wr_count) begin
      count_d = csr_di;
    end else if (en_q && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end else if (w_timer_evt) begin
      if (auto_q) begin
        count_d = reload_q;
      end else begin
        // One-shot expiry overrides whatever a same-cycle CTRL write asked.
        en_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux (zero-extended) and interrupt vector
  // --------------------------------------------------------------------------
  always_comb begin
    csr_do_d = '0;
    if (w_sel) begin
      case (w_idx)
        C_REG_PENDING: csr_do_d[NB-1:0] = pending_q;
        C_REG_MASK:    csr_do_d[NB-1:0] = mask_q;
        C_REG_EDGE:    csr_do_d[NB-1:0] = w_edge_full;
        C_REG_CTRL:    csr_do_d[1:0]    = {auto_q, en_q};
        C_REG_RELOAD:  csr_do_d         = reload_q;
        C_REG_COUNT:   csr_do_d         = count_q;
        default:       csr_do_d         = '0;
      endcase
    end
  end

  always_comb begin
    irq_d         = '0;
    irq_d[NB-1:0] = pending_q & mask_q;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      src_prev_q <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      csr_do     <= '0;
      irq_o      <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      src_prev_q <= irq_src;
      en_q       <= en_d;
      auto_q     <= auto_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      csr_do     <= csr_do_d;
      irq_o      <= irq_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_timer_ctrl
//  Purpose  : Self-checking bench for irq_timer_ctrl. Single-cycle vectors
//             carry their own expected csr_do / irq_o values; expectations
//             are queued when a vector is driven and popped after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer_ctrl;

  localparam int unsigned NSRC = 8;

  logic            clk;
  logic            rst;
  logic [13:0]     csr_a;
  logic            csr_we;
  logic [31:0]     csr_di;
  logic [31:0]     csr_do;
  logic [NSRC-1:0] irq_src;
  logic [31:0]     irq_o;

  int n_tests;
  int n_fail;

  irq_timer_ctrl #(
    .CSR_ADDR (4'h4),
    .NSRC     (NSRC)
  ) u_dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq_src (irq_src),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      bank;
    logic [3:0]      idx;
    logic            we;
    logic [31:0]     di;
    logic [NSRC-1:0] src;
    logic            chk_do;
    logic [31:0]     exp_do;
    logic            chk_irq;
    logic [31:0]     exp_irq;
    string           name;
  } vec_t;

  typedef struct {
    logic        chk_do;
    logic [31:0] exp_do;
    logic        chk_irq;
    logic [31:0] exp_irq;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] bank, input logic [3:0] idx, input logic we,
                     input logic [31:0] di, input logic [NSRC-1:0] src,
                     input logic chk_do, input logic [31:0] exp_do,
                     input logic chk_irq, input logic [31:0] exp_irq, input string name);
    vec_t v;
    v.bank = bank; v.idx = idx; v.we = we; v.di = di; v.src = src;
    v.chk_do = chk_do; v.exp_do = exp_do; v.chk_irq = chk_irq; v.exp_irq = exp_irq;
    v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input logic [3:0] bank, input logic [3:0] idx, input logic we,
                       input logic [31:0] di, input logic [NSRC-1:0] src,
                       input logic chk_do, input logic [31:0] exp_do,
                       input logic chk_irq, input logic [31:0] exp_irq, input string name);
    exp_t e;
    @(negedge clk);
    csr_a   = {bank, 6'd0, idx};
    csr_we  = we;
    csr_di  = di;
    irq_src = src;
    e.chk_do = chk_do; e.exp_do = exp_do; e.chk_irq = chk_irq; e.exp_irq = exp_irq;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if (e.chk_do)  check({e.name, "_do"},  csr_do, e.exp_do);
      if (e.chk_irq) check({e.name, "_irq"}, irq_o,  e.exp_irq);
    end
    csr_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n_evt;
    logic hit;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    csr_a   = '0;
    csr_we  = 1'b0;
    csr_di  = '0;
    irq_src = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- reset values ----------------
    add(4, 0, 0, 0, 8'h00, 1, 32'h000, 1, 0, "rst_pending");
    add(4, 1, 0, 0, 8'h00, 1, 32'h000, 1, 0, "rst_mask");
    add(4, 2, 0, 0, 8'h00, 1, 32'h100, 1, 0, "rst_edge");
    add(4, 3, 0, 0, 8'h00, 1, 32'h000, 1, 0, "rst_ctrl");
    add(4, 4, 0, 0, 8'h00, 1, 32'h000, 1, 0, "rst_reload");
    add(4, 5, 0, 0, 8'h00, 1, 32'h000, 1, 0, "rst_count");
    // ---------------- edge source 0 ----------------
    add(4, 2, 1, 32'h1, 8'h00, 0, 0, 1, 0, "wr_edge");
    add(4, 1, 1, 32'h1, 8'h00, 0, 0, 1, 0, "wr_mask");
    add(4, 2, 0, 0,     8'h00, 1, 32'h101, 1, 0, "rd_edge");
    add(4, 0, 0, 0,     8'h01, 1, 32'h000, 1, 0, "edge_pulse");
    add(4, 0, 0, 0,     8'h00, 1, 32'h001, 1, 1, "edge_pend");
    add(4, 0, 1, 32'h1, 8'h00, 0, 0,       1, 1, "edge_w1c");
    add(4, 0, 0, 0,     8'h00, 1, 32'h000, 1, 0, "edge_clr");
    add(4, 0, 1, 32'h1, 8'h01, 0, 0,       1, 0, "edge_setwin");
    add(4, 0, 0, 0,     8'h01, 1, 32'h001, 1, 1, "edge_setwin_pend");
    add(4, 0, 1, 32'h1, 8'h01, 0, 0,       1, 1, "edge_held_w1c");
    add(4, 0, 0, 0,     8'h00, 1, 32'h000, 1, 0, "edge_held_clr");
    // ---------------- level source 1 ----------------
    add(4, 2, 1, 32'h0, 8'h00, 0, 0,       1, 0, "wr_edge0");
    add(4, 1, 1, 32'h2, 8'h00, 0, 0,       1, 0, "wr_mask2");
    add(4, 2, 0, 0,     8'h02, 1, 32'h100, 1, 0, "lvl_set");
    add(4, 0, 1, 32'h2, 8'h02, 0, 0,       1, 2, "lvl_w1c_held");
    add(4, 0, 0, 0,     8'h00, 1, 32'h002, 1, 2, "lvl_stays");
    add(4, 0, 0, 0,     8'h00, 1, 32'h002, 1, 2, "lvl_no_selfclr");
    add(4, 0, 1, 32'h2, 8'h00, 0, 0,       1, 2, "lvl_w1c");
    add(4, 0, 0, 0,     8'h00, 1, 32'h000, 1, 0, "lvl_clr");
    // ---------------- CSR decode ----------------
    add(5, 1, 1, 32'hFF,       8'h00, 1, 32'h000, 1, 0, "bank5_wr");
    add(4, 1, 0, 0,            8'h00, 1, 32'h002, 1, 0, "mask_unchanged");
    add(5, 1, 0, 0,            8'h00, 1, 32'h000, 1, 0, "bank5_rd");
    add(4, 9, 0, 0,            8'h00, 1, 32'h000, 1, 0, "rd_reg9");
    add(4, 9, 1, 32'hFFFFFFFF, 8'h00, 0, 0,       1, 0, "wr_reg9");
    add(4, 3, 0, 0,            8'h00, 1, 32'h000, 1, 0, "ctrl_after_reg9");
    add(4, 3, 1, 32'hFFFFFFFC, 8'h00, 0, 0,       1, 0, "wr_ctrl_hi");
    add(4, 3, 0, 0,            8'h00, 1, 32'h000, 1, 0, "ctrl_hi_reads0");

    foreach (vecs[i]) begin
      apply(vecs[i].bank, vecs[i].idx, vecs[i].we, vecs[i].di, vecs[i].src,
            vecs[i].chk_do, vecs[i].exp_do, vecs[i].chk_irq, vecs[i].exp_irq, vecs[i].name);
    end

    // ---------------- timer, auto-reload: RELOAD=4 -> event every 5 cycles --
    apply(4, 4, 1, 32'd4,     8'h00, 0, 0, 0, 0, "t_reload");
    apply(4, 5, 1, 32'd4,     8'h00, 0, 0, 0, 0, "t_count");
    apply(4, 1, 1, 32'h100,   8'h00, 0, 0, 0, 0, "t_mask");
    apply(4, 3, 1, 32'd3,     8'h00, 0, 0, 0, 0, "t_ctrl");
    n_evt = 0;
    for (int k = 1; k <= 16; k++) begin
      // W1C every cycle; csr_do shows PENDING before the clear takes effect.
      hit = (k == 6) || (k == 11) || (k == 16);
      apply(4, 0, 1, 32'h100, 8'h00, 1, hit ? 32'h100 : 32'h0,
            1, hit ? 32'h100 : 32'h0, $sformatf("auto_%0d", k));
      if (csr_do[8]) n_evt++;
    end
    check("auto_event_count", n_evt, 3);

    // ---------------- timer, one-shot: COUNT=2, EN=1 ----------------
    apply(4, 3, 1, 32'd0,   8'h00, 0, 0, 0, 0, "os_stop");
    apply(4, 5, 1, 32'd2,   8'h00, 0, 0, 0, 0, "os_count");
    apply(4, 3, 1, 32'd1,   8'h00, 0, 0, 0, 0, "os_ctrl");
    for (int t = 1; t <= 4; t++) begin
      apply(4, 0, 0, 0, 8'h00, 1, (t == 4) ? 32'h100 : 32'h0,
            1, (t == 4) ? 32'h100 : 32'h0, $sformatf("os_%0d", t));
    end
    apply(4, 3, 0, 0,       8'h00, 1, 32'h0, 1, 32'h100, "os_ctrl_rd");
    apply(4, 5, 0, 0,       8'h00, 1, 32'h0, 1, 32'h100, "os_count_rd");
    apply(4, 0, 1, 32'h100, 8'h00, 0, 0,     1, 32'h100, "os_w1c");
    for (int t = 0; t < 6; t++) begin
      apply(4, 0, 0, 0, 8'h00, 1, 32'h0, 1, 32'h0, $sformatf("os_quiet_%0d", t));
    end

    // ---------------- COUNT write beats decrement ----------------
    apply(4, 5, 1, 32'd100, 8'h00, 0, 0,      0, 0, "cw_count");
    apply(4, 3, 1, 32'd1,   8'h00, 0, 0,      0, 0, "cw_ctrl");
    apply(4, 5, 0, 0,       8'h00, 1, 32'd100, 0, 0, "cw_rd100");
    apply(4, 5, 1, 32'd7,   8'h00, 0, 0,      0, 0, "cw_wr7");
    apply(4, 5, 0, 0,       8'h00, 1, 32'd7,  0, 0, "cw_rd7");

    // ---------------- asynchronous reset mid-count ----------------
    apply(4, 1, 1, 32'h102, 8'h02, 0, 0,       0, 0,     "pr_mask");
    apply(4, 5, 1, 32'd100, 8'h00, 0, 0,       1, 32'h2, "pr_count");
    apply(4, 5, 0, 0,       8'h00, 1, 32'd100, 1, 32'h2, "pr_rd");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_do",  csr_do, 32'h0);
    check("rst_async_irq", irq_o,  32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(4, 0, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_pending");
    apply(4, 1, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_mask");
    apply(4, 2, 0, 0, 8'h00, 1, 32'h100, 1, 0, "post_edge");
    apply(4, 3, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_ctrl");
    apply(4, 4, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_reload");
    apply(4, 5, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_count");
    repeat (3) apply(4, 9, 0, 0, 8'h00, 0, 0, 0, 0, "post_idle");
    apply(4, 5, 0, 0, 8'h00, 1, 32'h000, 1, 0, "post_count_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
